// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, stage-1 states, result flags.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOADED = 2'd1,
      ST_MUL    = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic ovf;
   } flags_t;

   // MUL is the only opcode that parks stage 1 for several cycles.
   function automatic logic op_is_mul(op_e op);
      return (op == OP_MUL);
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between producer, ALU and consumer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs.
interface alu_pipe_if #(
   parameter int WIDTH = 4
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_e              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             ovf;

   // ALU side
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero, ovf
   );

   // Producer/consumer side
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero, ovf
   );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: start at edge N, product complete after edge N+WIDTH; o_done high in the last iteration cycle.
// Backpressure: none; caller must not restart while busy. Product holds until the next start.
module alu_seq_mul #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);

   localparam int CW = $clog2(WIDTH);

   logic               r_busy;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic               w_last;

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // Load operands on start, then add one shifted multiplicand per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_acc    <= '0;
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done = r_busy && w_last;
   assign o_prod = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage handshaked ALU: stage 1 holds operands (or iterates a MUL), stage 2 holds result+flags.
// Latency: non-MUL result valid one edge after accept; MUL valid WIDTH+1 edges after accept.
// Backpressure: in_ready drops when stage 1 is busy with MUL, or LOADED behind a stalled stage 2.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 4   // power of two, >= 4
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      flags_t           fl;
   } alu_res_t;

   // Single-cycle datapath: result plus carry/zero/ovf for every non-MUL opcode.
   function automatic alu_res_t alu_fn(op_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      alu_res_t       r;
      logic [WIDTH:0] ext;
      logic [SHW-1:0] sh;
      r   = '0;
      ext = '0;
      sh  = b[SHW-1:0];
      case (op)
         OP_ADD: begin
            ext        = {1'b0, a} + {1'b0, b};
            r.res      = ext[WIDTH-1:0];
            r.fl.carry = ext[WIDTH];
            r.fl.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (r.res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // Top bit of the extended difference is the borrow (a < b unsigned).
            ext        = {1'b0, a} - {1'b0, b};
            r.res      = ext[WIDTH-1:0];
            r.fl.carry = ext[WIDTH];
            r.fl.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (r.res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: r.res = a & b;
         OP_OR:  r.res = a | b;
         OP_XOR: r.res = a ^ b;
         OP_SHL: begin
            // The guard bit above the MSB catches the last bit shifted out; stays 0 for sh=0.
            ext        = {1'b0, a} << sh;
            r.res      = ext[WIDTH-1:0];
            r.fl.carry = ext[WIDTH];
         end
         OP_SHR: begin
            // Guard bit below the LSB catches the last bit shifted out.
            ext        = {a, 1'b0} >> sh;
            r.res      = ext[WIDTH:1];
            r.fl.carry = ext[0];
         end
         default: r = '0;
      endcase
      r.fl.zero = (r.res == '0);
      return r;
   endfunction

   state_e             r_state;
   state_e             w_state_nxt;
   op_e                r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   flags_t             r_flags;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_s2_free;
   logic               w_s2_load;
   logic               w_mul_start;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   alu_res_t           w_s1_res;

   assign w_s2_free   = !r_out_valid || bus.out_ready;
   assign w_s2_load   = (r_state == ST_LOADED) && w_s2_free;
   assign w_in_ready  = (r_state == ST_EMPTY) || w_s2_load;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_mul_start = w_accept && op_is_mul(bus.op);

   // Multiplier takes operands straight off the bus so iteration starts on the next edge.
   alu_seq_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_mul_start),
      .i_a     (bus.a),
      .i_b     (bus.b),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   // Stage-1 result: finished product for MUL, otherwise the combinational ALU.
   always_comb begin
      w_s1_res = '0;
      if (op_is_mul(r_op)) begin
         w_s1_res.res      = w_prod[WIDTH-1:0];
         w_s1_res.fl.carry = |w_prod[2*WIDTH-1:WIDTH];
         w_s1_res.fl.zero  = (w_prod[WIDTH-1:0] == '0);
         w_s1_res.fl.ovf   = 1'b0;
      end else begin
         w_s1_res = alu_fn(r_op, r_a, r_b);
      end
   end

   // Stage-1 state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Stage-1 next state: accept, iterate MUL, or hand off to stage 2.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = op_is_mul(bus.op) ? ST_MUL : ST_LOADED;
            end
         end
         ST_LOADED: begin
            if (w_s2_load) begin
               if (w_accept) begin
                  w_state_nxt = op_is_mul(bus.op) ? ST_MUL : ST_LOADED;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_state_nxt = ST_LOADED;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Operands and opcode are captured only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op <= OP_ADD;
         r_a  <= '0;
         r_b  <= '0;
      end else if (w_accept) begin
         r_op <= bus.op;
         r_a  <= bus.a;
         r_b  <= bus.b;
      end
   end

   // Stage 2: load from stage 1 when free, otherwise drop valid after a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_s1_res.res;
         r_flags     <= w_s1_res.fl;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.carry     = r_flags.carry;
   assign bus.zero      = r_flags.zero;
   assign bus.ovf       = r_flags.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=4: directed vectors with hand-computed results.
// Driver pushes expected {result,carry,zero,ovf} on accept; monitor pops on each output transfer.
// Also checks latency, backpressure hold, in_ready behaviour and reset during MUL.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef logic [6:0] exp_t;   // {result[3:0], carry, zero, ovf}

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(4)) bus();

   alu_pipe #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb[$];
   int   pop_cyc[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic stall_prev = 1'b0;
   exp_t held = '0;

   op_e        v_op[8];
   logic [3:0] v_a[8];
   logic [3:0] v_b[8];
   exp_t       v_e[8];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(logic [3:0] r, logic c, logic z, logic o);
      return {r, c, z, o};
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(string name);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Drive one beat, wait for accept, push its expected response, then scramble the bus.
   task automatic send(op_e op, logic [3:0] a, logic [3:0] b, exp_t e);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         n++;
      end
      if (acc) sb.push_back(e);
      else fail_now("send_timeout");
      #1;
      bus.in_valid = 1'b0;
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      bus.op = op_e'(3'($urandom));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) fail_now("drain_timeout");
   endtask

   // Monitor: pop and compare on every transfer; check hold while stalled.
   always @(negedge clk) begin
      exp_t got;
      got = {bus.result, bus.carry, bus.zero, bus.ovf};
      if (stall_prev && rst_n) check("hold", {bus.out_valid, got}, {1'b1, held});
      stall_prev = rst_n && bus.out_valid && !bus.out_ready;
      held = got;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) fail_now("unexpected_result");
         else begin
            check("result", got, sb.pop_front());
            pop_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      v_op = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_SHR};
      v_a  = '{4'hC, 4'h5, 4'hF, 4'h8, 4'h8, 4'h9, 4'h8, 4'h3};
      v_b  = '{4'hA, 4'hA, 4'hF, 4'h8, 4'h1, 4'h5, 4'h0, 4'h2};
      v_e  = '{mk(4'h8,0,0,0), mk(4'hF,0,0,0), mk(4'h0,0,1,0), mk(4'h0,1,1,1),
               mk(4'h7,0,0,1), mk(4'h2,1,0,0), mk(4'h8,0,0,0), mk(4'h0,1,1,0)};

      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0;
      bus.b = '0;
      bus.op = OP_ADD;

      // Reset state
      #12;
      check("rst_out", {bus.out_valid, bus.result, bus.carry, bus.zero, bus.ovf}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_rdy", bus.in_ready, 1);

      // ADD F+1 with latency check
      send(OP_ADD, 4'hF, 4'h1, mk(4'h0, 1, 1, 0));
      check("add_lat_n", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("add_lat_n1", {bus.out_valid, bus.result, bus.carry, bus.zero, bus.ovf},
            {1'b1, mk(4'h0, 1, 1, 0)});
      wait_drain();

      // SUB borrow, then ADD signed overflow
      send(OP_SUB, 4'h3, 4'h5, mk(4'hE, 1, 0, 0));
      send(OP_ADD, 4'h7, 4'h1, mk(4'h8, 0, 0, 1));
      wait_drain();

      // Eight back-to-back mixed ops
      base = pop_cyc.size();
      for (int i = 0; i < 8; i++) send(v_op[i], v_a[i], v_b[i], v_e[i]);
      wait_drain();
      check("b2b_count", pop_cyc.size() - base, 8);
      if (pop_cyc.size() >= base + 8) check("b2b_span", pop_cyc[base+7] - pop_cyc[base], 7);

      // Backpressure: stage 2 stalled, stage 1 fills, in_ready drops
      bus.out_ready = 1'b0;
      send(OP_ADD, 4'h1, 4'h1, mk(4'h2, 0, 0, 0));
      check("s1_fill_rdy", bus.in_ready, 1);
      send(OP_XOR, 4'h5, 4'h3, mk(4'h6, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         check("stall_rdy", bus.in_ready, 0);
         check("stall_out", {bus.out_valid, bus.result}, {1'b1, 4'h2});
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(OP_OR, 4'h8, 4'h1, mk(4'h9, 0, 0, 0));
      send(OP_SHL, 4'h3, 4'h3, mk(4'h8, 1, 0, 0));
      wait_drain();

      // MUL 7*3 = 0x15 with iteration timing
      send(OP_MUL, 4'h7, 4'h3, mk(4'h5, 1, 0, 0));
      check("mul_rdy_n", bus.in_ready, 0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         check("mul_iter", {bus.in_ready, bus.out_valid}, 0);
      end
      @(posedge clk);
      #1;
      check("mul_n4", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("mul_n5", {bus.out_valid, bus.result, bus.carry}, {1'b1, 4'h5, 1'b1});
      wait_drain();

      // Back-to-back MULs followed by a single-cycle op
      send(OP_MUL, 4'hF, 4'hF, mk(4'h1, 1, 0, 0));
      send(OP_MUL, 4'h4, 4'h4, mk(4'h0, 1, 1, 0));
      send(OP_MUL, 4'h2, 4'h3, mk(4'h6, 0, 0, 0));
      send(OP_ADD, 4'h1, 4'h2, mk(4'h3, 0, 0, 0));
      wait_drain();

      // Reset during the 2nd MUL iteration discards it
      send(OP_MUL, 4'h5, 4'h5, mk(4'h9, 1, 0, 0));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("rst_mul", {bus.out_valid, bus.result, bus.carry, bus.zero, bus.ovf}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_mul_rdy", bus.in_ready, 1);
      send(OP_ADD, 4'h2, 4'h2, mk(4'h4, 0, 0, 0));
      @(posedge clk);
      #1;
      check("post_rst_add", {bus.out_valid, bus.result}, {1'b1, 4'h4});
      wait_drain();
      repeat (10) @(posedge clk);
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
